control_necesidades: RTL and testbench

CONTROL_NECESIDADES -- requirements
Module: control_necesidades

---
 rtl/control_necesidades_pkg.sv | 31 +++
 rtl/celda_necesidad.sv | 45 ++++
 rtl/control_necesidades.sv | 124 ++++++++++++
 tb/tb_control_necesidades.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/control_necesidades_pkg.sv
// Shared definitions for the pet-needs controller: stat geometry, action step,
// reset level and life-state encodings.
// Used by the top level and by every stat cell so widths and constants agree.
package control_necesidades_pkg;

    localparam int STAT_W = 3;
    localparam int CNT_W  = 5;

    typedef logic [STAT_W-1:0] stat_t;

    localparam stat_t STAT_MAX  = 3'd7;
    localparam stat_t STAT_RST  = 3'd5;
    localparam stat_t STAT_STEP = 3'd2;

    typedef enum logic [1:0] {
        VIVO    = 2'b00,
        CRITICO = 2'b01,
        MUERTO  = 2'b10
    } estado_t;

    // Add with a clamp at STAT_MAX; the sum is formed one bit wider so
    // 7 + 2 cannot wrap around before the clamp.
    function automatic stat_t sat_add(input stat_t s, input stat_t step);
        logic [STAT_W:0] sum;
        sum = {1'b0, s} + {1'b0, step};
        if (sum > {1'b0, STAT_MAX})
            return STAT_MAX;
        return sum[STAT_W-1:0];
    endfunction

endpackage

// File: rtl/celda_necesidad.sv
// One need stat: 3-bit level with saturating +STEP on action and -1 decay
// every PERIOD ticks.  Latency: one clock from tick/evento to nivel.
// Ports: clk, reset (sync, active-high), tick and evento (already gated by the
// caller while the pet is dead), nivel (registered stat level).
module celda_necesidad
    import control_necesidades_pkg::*;
#(
    parameter int PERIOD = 5
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  tick,
    input  logic  evento,
    output stat_t nivel
);

    logic [CNT_W-1:0] cnt;
    logic             decae;
    stat_t            base;

    // The counter is compared one short of PERIOD so that the tick which
    // would make it reach PERIOD is the tick that decays the stat.
    always_comb begin
        decae = tick && (cnt == CNT_W'(PERIOD - 1));
        base  = (decae && (nivel != '0)) ? nivel - STAT_W'(1) : nivel;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            nivel <= STAT_RST;
            cnt   <= '0;
        end else if (evento) begin
            // A same-cycle decay is applied first, then the action step.
            nivel <= sat_add(base, STAT_STEP);
            cnt   <= '0;
        end else begin
            nivel <= base;
            if (decae)
                cnt <= '0;
            else if (tick)
                cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/control_necesidades.sv
// Pet-needs controller: game-tick prescaler, button edge detection, five
// decaying stats and a VIVO/CRITICO/MUERTO life FSM.
// Ports: clk, reset (sync, active-high), five action buttons, botontest
// (faster ticks), five registered 3-bit stat outputs, registered 2-bit estado.
module control_necesidades
    import control_necesidades_pkg::*;
#(
    parameter int TICK_CYCLES = 50000000,
    parameter int TEST_DIV    = 10,
    parameter int P_HUM       = 5,
    parameter int P_NUT       = 7,
    parameter int P_ENE       = 10,
    parameter int P_MAN       = 12,
    parameter int P_COR       = 15,
    parameter int CRIT_TICKS  = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        botonregar,
    input  logic        botonalimentar,
    input  logic        botondormir,
    input  logic        botonlimpiar,
    input  logic        botoncortar,
    input  logic        botontest,
    output stat_t       humedad,
    output stat_t       nutricion,
    output stat_t       energia,
    output stat_t       mantenimiento,
    output stat_t       cortado,
    output logic [1:0]  estado
);

    localparam int            PW        = $clog2(TICK_CYCLES) + 1;
    localparam logic [PW-1:0] TERM_NORM = PW'(TICK_CYCLES - 1);
    localparam logic [PW-1:0] TERM_TEST = PW'(TICK_CYCLES / TEST_DIV - 1);

    logic [PW-1:0]    presc;
    logic [PW-1:0]    term;
    logic             tick;
    logic [4:0]       boton;
    logic [4:0]       boton_q;
    logic [4:0]       evento;
    logic             vivo;
    logic             tick_vivo;
    logic [2:0]       ceros;
    logic [CNT_W-1:0] crit;
    estado_t          est;

    assign boton = {botoncortar, botonlimpiar, botondormir, botonalimentar, botonregar};

    // Terminal count follows botontest live; ">=" makes a switch to the
    // shorter period fire at once if the count is already past it.
    always_comb begin
        term = botontest ? TERM_TEST : TERM_NORM;
        tick = (presc >= term);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc   <= '0;
            boton_q <= '0;
        end else begin
            presc   <= tick ? '0 : presc + PW'(1);
            boton_q <= boton;
        end
    end

    // Once dead, the stats see neither ticks nor button events.
    always_comb begin
        vivo      = (est != MUERTO);
        tick_vivo = tick && vivo;
        evento    = (boton & ~boton_q) & {5{vivo}};
        ceros     = 3'(humedad == '0) + 3'(nutricion == '0) + 3'(energia == '0)
                  + 3'(mantenimiento == '0) + 3'(cortado == '0);
    end

    celda_necesidad #(.PERIOD(P_HUM)) u_hum (
        .clk(clk), .reset(reset), .tick(tick_vivo), .evento(evento[0]), .nivel(humedad));
    celda_necesidad #(.PERIOD(P_NUT)) u_nut (
        .clk(clk), .reset(reset), .tick(tick_vivo), .evento(evento[1]), .nivel(nutricion));
    celda_necesidad #(.PERIOD(P_ENE)) u_ene (
        .clk(clk), .reset(reset), .tick(tick_vivo), .evento(evento[2]), .nivel(energia));
    celda_necesidad #(.PERIOD(P_MAN)) u_man (
        .clk(clk), .reset(reset), .tick(tick_vivo), .evento(evento[3]), .nivel(mantenimiento));
    celda_necesidad #(.PERIOD(P_COR)) u_cor (
        .clk(clk), .reset(reset), .tick(tick_vivo), .evento(evento[4]), .nivel(cortado));

    // Life FSM looks at the registered stats, so it lags a stat change by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            est  <= VIVO;
            crit <= '0;
        end else begin
            case (est)
                VIVO: begin
                    if (ceros >= 3'd2)
                        est <= MUERTO;
                    else if (ceros == 3'd1)
                        est <= CRITICO;
                end
                CRITICO: begin
                    if (ceros >= 3'd2) begin
                        est  <= MUERTO;
                        crit <= '0;
                    end else if (ceros == 3'd0) begin
                        est  <= VIVO;
                        crit <= '0;
                    end else if (tick) begin
                        if (crit == CNT_W'(CRIT_TICKS - 1)) begin
                            est  <= MUERTO;
                            crit <= '0;
                        end else begin
                            crit <= crit + CNT_W'(1);
                        end
                    end
                end
                default: est <= MUERTO;
            endcase
        end
    end

    assign estado = est;

endmodule

// File: tb/tb_control_necesidades.sv
module tb_control_necesidades;

    localparam int TC   = 10;
    localparam int TD   = 5;
    localparam int CRIT = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] btn = '0;
    logic       botontest = 1'b0;
    logic [2:0] humedad, nutricion, energia, mantenimiento, cortado;
    logic [1:0] estado;

    always #5 clk = ~clk;

    control_necesidades #(
        .TICK_CYCLES(TC), .TEST_DIV(TD),
        .P_HUM(2), .P_NUT(3), .P_ENE(4), .P_MAN(5), .P_COR(6),
        .CRIT_TICKS(CRIT)
    ) dut (
        .clk(clk), .reset(reset),
        .botonregar(btn[0]), .botonalimentar(btn[1]), .botondormir(btn[2]),
        .botonlimpiar(btn[3]), .botoncortar(btn[4]), .botontest(botontest),
        .humedad(humedad), .nutricion(nutricion), .energia(energia),
        .mantenimiento(mantenimiento), .cortado(cortado), .estado(estado)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Game rules: stats in 0..7, +2 on a button press (clamped), -1 after
    // every P ticks (clamped), life state from the number of empty stats.
    int ms[5];
    int mdecay[5];
    int mprev[5];
    int mcycles;          // cycles since the last tick
    int mlife;            // 0 alive, 1 critical, 2 dead
    int mcrit;            // ticks spent critical
    int ecount = 0;       // non-reset clock edges since the last reset
    bit mvalid = 0;
    int per[5] = '{2, 3, 4, 5, 6};

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 5; i++) begin
                ms[i] = 5; mdecay[i] = 0; mprev[i] = 0;
            end
            mcycles = 0; mlife = 0; mcrit = 0; ecount = 0; mvalid = 1;
        end else begin
            int period, empty;
            bit tk;
            ecount++;
            period = botontest ? TC / TD : TC;
            tk = (mcycles + 1 >= period);
            mcycles = tk ? 0 : mcycles + 1;
            empty = 0;
            for (int i = 0; i < 5; i++) if (ms[i] == 0) empty++;
            if (mlife != 2) begin
                for (int i = 0; i < 5; i++) begin
                    int s;
                    bit press;
                    s = ms[i];
                    press = btn[i] && (mprev[i] == 0);
                    if (tk) begin
                        mdecay[i]++;
                        if (mdecay[i] == per[i]) begin
                            mdecay[i] = 0;
                            s = (s > 0) ? s - 1 : 0;
                        end
                    end
                    if (press) begin
                        s = (s + 2 > 7) ? 7 : s + 2;
                        mdecay[i] = 0;
                    end
                    ms[i] = s;
                end
            end
            for (int i = 0; i < 5; i++) mprev[i] = int'(btn[i]);
            if (mlife == 0) begin
                if (empty >= 2) mlife = 2;
                else if (empty == 1) mlife = 1;
            end else if (mlife == 1) begin
                if (empty >= 2) begin mlife = 2; mcrit = 0; end
                else if (empty == 0) begin mlife = 0; mcrit = 0; end
                else if (tk) begin
                    mcrit++;
                    if (mcrit == CRIT) begin mlife = 2; mcrit = 0; end
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (mvalid) begin
            chk("humedad", int'(humedad), ms[0]);
            chk("nutricion", int'(nutricion), ms[1]);
            chk("energia", int'(energia), ms[2]);
            chk("mantenimiento", int'(mantenimiento), ms[3]);
            chk("cortado", int'(cortado), ms[4]);
            chk("estado", int'(estado), mlife);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        btn = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Return at the negedge after clock edge k (counted from reset release).
    task automatic go_to(input int k);
        while (ecount < k) @(negedge clk);
    endtask

    task automatic chk_all(input string tag, input int h, input int n, input int e,
                           input int m, input int c, input int st);
        chk({tag, ".hum"}, int'(humedad), h);
        chk({tag, ".nut"}, int'(nutricion), n);
        chk({tag, ".ene"}, int'(energia), e);
        chk({tag, ".man"}, int'(mantenimiento), m);
        chk({tag, ".cor"}, int'(cortado), c);
        chk({tag, ".estado"}, int'(estado), st);
    endtask

    initial begin
        // Run A: idle decay into CRITICO, then MUERTO, frozen, then reset.
        do_reset();
        chk_all("reset", 5, 5, 5, 5, 5, 0);
        go_to(10);  chk_all("idle10", 5, 5, 5, 5, 5, 0);
        go_to(19);  chk("hum_e19", int'(humedad), 5);
        go_to(20);  chk("hum_e20", int'(humedad), 4);
        go_to(100); chk("hum_e100", int'(humedad), 0);
                    chk("est_e100", int'(estado), 0);
        go_to(101); chk("est_e101", int'(estado), 1);
        go_to(139); chk("est_e139", int'(estado), 1);
        go_to(140); chk_all("dead140", 0, 1, 2, 3, 3, 2);
        go_to(144); btn = 5'h1f;
        go_to(150); chk_all("dead150", 0, 1, 2, 3, 3, 2);
        btn = '0;
        go_to(159);
        reset = 1'b1; btn[0] = 1'b1;      // reset lands on a tick with an edge pending
        @(negedge clk);
        chk_all("rst_dead", 5, 5, 5, 5, 5, 0);
        reset = 1'b0;                     // button still high -> event on first cycle
        go_to(1);   chk("hum_post_rst", int'(humedad), 7);
        btn = '0;

        // Run B: press on the very cycle humedad decays from 1.
        do_reset();
        go_to(99);  btn[0] = 1'b1;
        go_to(100); chk("hum_dec_press", int'(humedad), 2);
        btn = '0;
        go_to(119); chk("hum_e119", int'(humedad), 2);
        go_to(120); chk("hum_e120", int'(humedad), 1);

        // Run C: held button gives one event; press at 7 saturates.
        do_reset();
        btn[0] = 1'b1;
        go_to(1);   chk("hold_e1", int'(humedad), 7);
        go_to(19);  chk("hold_e19", int'(humedad), 7);
        go_to(20);  chk("hold_e20", int'(humedad), 6);
        go_to(50);  btn = '0;
        go_to(51);  chk("hold_e51", int'(humedad), 5);
        btn[0] = 1'b1;
        go_to(52);  chk("press_5", int'(humedad), 7);
        btn = '0;
        go_to(53);  btn[0] = 1'b1;
        go_to(54);  chk("press_sat", int'(humedad), 7);
        btn = '0;

        // Run D: accelerated ticks and a mid-count switch of botontest.
        botontest = 1'b1;
        do_reset();
        go_to(3);   chk("test_e3", int'(humedad), 5);
        go_to(4);   chk("test_e4", int'(humedad), 4);
        botontest = 1'b0;
        go_to(10);  botontest = 1'b1;
        go_to(12);  chk("switch_e12", int'(humedad), 4);
        go_to(13);  chk("switch_e13", int'(humedad), 3);
        botontest = 1'b0;

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
